// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined channel multiplexer.
package mux_pkg;

    localparam logic MODE_DIRECT      = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            enable,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

    logic [2**SELW-1:0] req_pad;
    logic [SELW-1:0]    cand [N];

    assign req_pad = (2**SELW)'(req);

    // cand[k] is the channel visited k steps after ptr.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [SELW:0] sum;
            assign sum      = {1'b0, ptr} + (SELW+1)'(gi);
            assign cand[gi] = (sum >= N_EXT) ? SELW'(sum - N_EXT) : sum[SELW-1:0];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_pad[cand[k]]) begin
                gnt_valid = enable;
                gnt_idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// N-channel registered multiplexer with valid/ready handshakes; direct or round-robin select.
module pipe_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic [SELW-1:0]    out_ch_reg;
    logic [SELW-1:0]    ptr_reg;
    logic [SELW-1:0]    ptr_next;
    logic [WIDTH-1:0]   data_next;
    logic [2**SELW-1:0] valid_pad;
    logic               accept;
    logic               dir_valid;
    logic               rr_valid;
    logic [SELW-1:0]    rr_idx;
    logic               gnt_valid;
    logic [SELW-1:0]    gnt_idx;
    logic               xfer;

    assign accept    = !out_valid_reg || out_ready;
    assign valid_pad = (2**SELW)'(in_valid);
    // An out-of-range sel is masked here so it can never grant.
    assign dir_valid = ({1'b0, sel} < N_EXT) && valid_pad[sel];

    rr_arbiter #(.N(N)) u_rr (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .enable    (mode == MODE_ROUND_ROBIN),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    assign gnt_valid = rst_n && ((mode == MODE_ROUND_ROBIN) ? rr_valid : dir_valid);
    assign gnt_idx   = (mode == MODE_ROUND_ROBIN) ? rr_idx : sel;
    assign xfer      = accept && gnt_valid;
    assign ptr_next  = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = xfer && (gnt_idx == SELW'(gi));
        end
    endgenerate

    always_comb begin
        data_next = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                data_next = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_next;
            out_ch_reg    <= gnt_idx;
            if (mode == MODE_ROUND_ROBIN) begin
                ptr_reg <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: an N=4/WIDTH=32 and an N=3/WIDTH=8 instance against a transaction-level model.
module tb_pipe_mux;
    import mux_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         mode4, out_ready4, out_valid4;
    logic [1:0]   sel4, out_ch4;
    logic [3:0]   in_valid4, in_ready4;
    logic [127:0] in_data4;
    logic [31:0]  out_data4;

    logic         mode3, out_ready3, out_valid3;
    logic [1:0]   sel3, out_ch3;
    logic [2:0]   in_valid3, in_ready3;
    logic [23:0]  in_data3;
    logic [7:0]   out_data3;

    int checks = 0;
    int errors = 0;

    // Model of each output register: held beat, its channel, and the RR start point.
    bit          m4_v, m3_v;
    logic [31:0] m4_d;
    logic [7:0]  m3_d;
    int          m4_ch, m3_ch, m4_ptr, m3_ptr;

    always #5 clk = ~clk;

    pipe_mux #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
        .out_ready(out_ready4)
    );

    pipe_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Which channel gets the grant, or -1 for none.
    function automatic int model_grant(input int n, input int md, input int s,
                                       input int valid, input int ptr);
        if (md == 0) begin
            if (s < n && ((valid >> s) & 1) == 1) return s;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int i;
            i = (ptr + k) % n;
            if (((valid >> i) & 1) == 1) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m4_v = 0; m4_d = '0; m4_ch = 0; m4_ptr = 0;
        m3_v = 0; m3_d = '0; m3_ch = 0; m3_ptr = 0;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        int g4, g3;
        bit a4, a3;
        #2;
        a4 = !m4_v || out_ready4;
        a3 = !m3_v || out_ready3;
        g4 = model_grant(4, int'(mode4), int'(sel4), int'(in_valid4), m4_ptr);
        g3 = model_grant(3, int'(mode3), int'(sel3), int'(in_valid3), m3_ptr);
        check("in_ready4", in_ready4, (a4 && g4 >= 0) ? (64'(1) << g4) : 64'd0);
        check("in_ready3", in_ready3, (a3 && g3 >= 0) ? (64'(1) << g3) : 64'd0);
        @(posedge clk);
        if (a4 && g4 >= 0) begin
            m4_v = 1; m4_d = in_data4[g4*32 +: 32]; m4_ch = g4;
            if (mode4 == MODE_ROUND_ROBIN) m4_ptr = (g4 + 1) % 4;
            $display("dut4 xfer ch=%0d data=%h", g4, m4_d);
        end else if (out_ready4) begin
            m4_v = 0;
        end
        if (a3 && g3 >= 0) begin
            m3_v = 1; m3_d = in_data3[g3*8 +: 8]; m3_ch = g3;
            if (mode3 == MODE_ROUND_ROBIN) m3_ptr = (g3 + 1) % 3;
            $display("dut3 xfer ch=%0d data=%h", g3, m3_d);
        end else if (out_ready3) begin
            m3_v = 0;
        end
        #1;
        check("out_valid4", out_valid4, m4_v);
        check("out_data4", out_data4, m4_d);
        check("out_ch4", out_ch4, m4_ch);
        check("out_valid3", out_valid3, m3_v);
        check("out_data3", out_data3, m3_d);
        check("out_ch3", out_ch3, m3_ch);
    endtask

    initial begin
        rst_n = 1'b0;
        mode4 = MODE_DIRECT; sel4 = 2'd0; in_valid4 = 4'hf; in_data4 = '0; out_ready4 = 1'b1;
        mode3 = MODE_DIRECT; sel3 = 2'd0; in_valid3 = 3'h7; in_data3 = '0; out_ready3 = 1'b1;
        model_reset();

        // Reset holds everything cleared even with requests pending.
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_out_valid", out_valid4, 0);
            check("rst_out_data", out_data4, 0);
            check("rst_out_ch", out_ch4, 0);
            check("rst_in_ready4", in_ready4, 0);
            check("rst_in_ready3", in_ready3, 0);
        end
        in_valid4 = '0; in_valid3 = '0;
        rst_n = 1'b1;
        step(); step();

        // Directed select.
        sel4 = 2'd2; in_valid4 = 4'b0100; in_data4[95:64] = 32'hDEADBEEF;
        #1 check("dir_in_ready", in_ready4, 4'b0100);
        step();
        check("dir_out_valid", out_valid4, 1);
        check("dir_out_data", out_data4, 32'hDEADBEEF);
        check("dir_out_ch", out_ch4, 2);
        sel4 = 2'd1;
        #1 check("dir_sel1_ready", in_ready4, 0);
        step();
        check("dir_sel1_drained", out_valid4, 0);

        // Round robin over all four channels.
        mode4 = MODE_ROUND_ROBIN; in_valid4 = 4'hf;
        for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'(i);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_seq_ch", out_ch4, 64'(k % 4));
            check("rr_seq_valid", out_valid4, 1);
        end

        // Backpressure then simultaneous drain and load.
        mode4 = MODE_DIRECT; sel4 = 2'd0; in_valid4 = 4'b0001; in_data4[31:0] = 32'h11;
        step();
        check("bp_loaded", out_data4, 32'h11);
        out_ready4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b0010; in_data4[63:32] = 32'h22;
        repeat (3) begin
            step();
            check("bp_hold_data", out_data4, 32'h11);
            check("bp_hold_ready", in_ready4, 0);
        end
        out_ready4 = 1'b1;
        #1 check("bp_release_ready", in_ready4, 4'b0010);
        step();
        check("bp_swap_valid", out_valid4, 1);
        check("bp_swap_data", out_data4, 32'h22);

        // N=3: wrap from ptr=2 to channel 0, then ptr=1.
        mode3 = MODE_ROUND_ROBIN; in_valid3 = 3'b010; in_data3 = 24'h332211;
        step();
        check("n3_first_ch", out_ch3, 1);
        in_valid3 = 3'b001;
        #1 check("n3_wrap_ready", in_ready3, 3'b001);
        step();
        check("n3_wrap_ch", out_ch3, 0);
        in_valid3 = 3'b111;
        #1 check("n3_ptr1_ready", in_ready3, 3'b010);
        step();
        mode3 = MODE_DIRECT; sel3 = 2'd3;
        repeat (3) begin
            #1 check("n3_sel3_ready", in_ready3, 0);
            step();
        end

        // Asynchronous reset between edges drops the held beat at once.
        mode4 = MODE_DIRECT; sel4 = 2'd0; in_valid4 = 4'b0001; in_data4[31:0] = 32'h55;
        out_ready4 = 1'b0;
        step();
        check("ar_pre_valid", out_valid4, 1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid4, 0);
        check("ar_out_data", out_data4, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mode4 = MODE_ROUND_ROBIN; in_valid4 = 4'hf; out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'(i);
        step();
        check("ar_rr_restart0", out_ch4, 0);
        step();
        check("ar_rr_restart1", out_ch4, 1);

        // Random traffic on both instances.
        for (int t = 0; t < 300; t++) begin
            mode4      = 1'($urandom_range(0, 1));
            sel4       = 2'($urandom_range(0, 3));
            in_valid4  = 4'($urandom);
            in_data4   = {$urandom, $urandom, $urandom, $urandom};
            out_ready4 = ($urandom_range(0, 3) != 0);
            mode3      = 1'($urandom_range(0, 1));
            sel3       = 2'($urandom_range(0, 3));
            in_valid3  = 3'($urandom);
            in_data3   = 24'($urandom);
            out_ready3 = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
